// File: rtl/aes_keyram_multi.sv
// Round-key store for AES-128/192/256. The key-expansion engine writes WR_W-bit words.
// The round datapath reads one 128-bit key per round, in forward or reverse order.
module aes_keyram_multi #(
  parameter int WR_W   = 64,
  parameter int MAX_RK = 15,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              kill,
  input  logic [1:0]        mode,
  input  logic              dir,
  input  logic              start,
  input  logic              en_wr,
  input  logic [ADDR_W-1:0] addr_wr,
  input  logic [WR_W-1:0]   key_round_wr,
  input  logic              key_ready,
  output logic [127:0]      key_round_rd,
  output logic [3:0]        rk_idx,
  output logic              rk_valid,
  output logic              rk_last,
  output logic              wr_err
);
  localparam int WPK   = 128 / WR_W;
  localparam int DEPTH = MAX_RK * WPK;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                     state;
  logic [3:0]                 ptr, nr_q;
  logic                       dir_q;
  logic [WR_W-1:0]            mem [DEPTH];
  logic                       wr_ok;
  logic [3:0]                 nr_sel, nxt_ptr, nxt_nr;
  logic                       nxt_dir, nxt_last, upd;
  logic [ADDR_W-1:0]          rd_base;
  logic [WPK-1:0][WR_W-1:0]   rd_words;

  // One extra bit so DEPTH == 2^ADDR_W still compares correctly.
  assign wr_ok = ({1'b0, addr_wr} < DEPTH_A);

  // Storage is deliberately not cleared by kill.
  always_ff @(posedge clk)
    if (!kill && en_wr && wr_ok) mem[addr_wr] <= key_round_wr;

  always_comb begin
    case (mode)
      2'b01:   nr_sel = 4'd12;
      2'b10:   nr_sel = 4'd14;
      default: nr_sel = 4'd10;
    endcase
  end

  // Start always wins over key_ready; key_ready only counts once running.
  always_comb begin
    upd     = 1'b0;
    nxt_ptr = ptr;
    nxt_nr  = nr_q;
    nxt_dir = dir_q;
    if (start) begin
      upd     = 1'b1;
      nxt_nr  = nr_sel;
      nxt_dir = dir;
      nxt_ptr = dir ? nr_sel : 4'd0;
    end else if (state == RUN && key_ready) begin
      upd = 1'b1;
      if (ptr == (dir_q ? 4'd0 : nr_q)) nxt_ptr = dir_q ? nr_q : 4'd0;
      else                              nxt_ptr = dir_q ? ptr - 4'd1 : ptr + 4'd1;
    end
    nxt_last = (nxt_ptr == (nxt_dir ? 4'd0 : nxt_nr));
  end

  // Lowest word of a key lands in the top bits of the 128-bit round key.
  assign rd_base = ADDR_W'(32'(nxt_ptr) * WPK);
  for (genvar j = 0; j < WPK; j++) begin : g_rd
    assign rd_words[WPK-1-j] = mem[rd_base + ADDR_W'(j)];
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      state        <= IDLE;
      ptr          <= '0;
      nr_q         <= '0;
      dir_q        <= 1'b0;
      key_round_rd <= '0;
      rk_idx       <= '0;
      rk_valid     <= 1'b0;
      rk_last      <= 1'b0;
      wr_err       <= 1'b0;
    end else begin
      wr_err <= en_wr && !wr_ok;
      if (upd) begin
        state        <= RUN;
        ptr          <= nxt_ptr;
        nr_q         <= nxt_nr;
        dir_q        <= nxt_dir;
        key_round_rd <= rd_words;
        rk_idx       <= nxt_ptr;
        rk_last      <= nxt_last;
        rk_valid     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_aes_keyram_multi.sv
// Self-checking bench for aes_keyram_multi (WR_W=64): directed sequences, a vector table
// and randomized traffic, all checked every cycle against a sequence-list reference model.
module tb_aes_keyram_multi;
  localparam int WR_W = 64, MAX_RK = 15, ADDR_W = 5, DEPTH = 30;

  logic              clk = 1'b0;
  logic              kill, start, dir, en_wr, key_ready;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] addr_wr;
  logic [WR_W-1:0]   key_round_wr;
  logic [127:0]      key_round_rd;
  logic [3:0]        rk_idx;
  logic              rk_valid, rk_last, wr_err;

  always #5 clk = ~clk;

  aes_keyram_multi #(.WR_W(WR_W), .MAX_RK(MAX_RK), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .kill(kill), .mode(mode), .dir(dir), .start(start), .en_wr(en_wr),
    .addr_wr(addr_wr), .key_round_wr(key_round_wr), .key_ready(key_ready),
    .key_round_rd(key_round_rd), .rk_idx(rk_idx), .rk_valid(rk_valid),
    .rk_last(rk_last), .wr_err(wr_err));

  typedef struct {
    bit kill, start, kr;
    bit [1:0] mode;
    bit dir, en;
    bit [4:0] addr;
    bit [63:0] data;
  } in_t;

  typedef struct {
    in_t i;
    int  idx;
    bit  valid, last, err;
  } vec_t;

  int checks = 0, errors = 0;

  // Reference model: the whole round-key order as a list, walked with a position.
  bit [63:0]    mm [DEPTH];
  int           seq[$];
  int           pos;
  bit           run;
  logic [127:0] e_key;
  int           e_idx;
  bit           e_valid, e_last, e_err;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic in_t nop();
    in_t v;
    v = '{default: 0};
    return v;
  endfunction

  function automatic logic [127:0] pat_key(int k);
    return {16'(16'hA000 + 2*k), 48'h0, 16'(16'hA001 + 2*k), 48'h0};
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model(input in_t v);
    int nr;
    bit load;
    if (v.kill) begin
      run = 0; e_idx = 0; e_valid = 0; e_last = 0; e_err = 0; e_key = '0;
      return;
    end
    e_err = v.en && (v.addr >= DEPTH);
    load  = 0;
    if (v.start) begin
      nr = (v.mode == 2'd1) ? 12 : (v.mode == 2'd2) ? 14 : 10;
      seq.delete();
      for (int i = 0; i <= nr; i++) seq.push_back(v.dir ? nr - i : i);
      pos = 0; run = 1; load = 1;
    end else if (run && v.kr) begin
      pos  = (pos + 1) % seq.size();
      load = 1;
    end
    if (load) begin
      e_idx   = seq[pos];
      e_valid = 1;
      e_last  = (pos == seq.size() - 1);
      e_key   = {mm[2*e_idx], mm[2*e_idx+1]};
    end
    if (v.en && v.addr < DEPTH) mm[v.addr] = v.data;
  endtask

  task automatic cyc(input in_t v);
    @(negedge clk);
    kill = v.kill; start = v.start; key_ready = v.kr; mode = v.mode; dir = v.dir;
    en_wr = v.en; addr_wr = v.addr; key_round_wr = v.data;
    @(posedge clk);
    #1;
    model(v);
    chk("m_idx",   128'(rk_idx),   128'(e_idx));
    chk("m_valid", 128'(rk_valid), 128'(e_valid));
    chk("m_last",  128'(rk_last),  128'(e_last));
    chk("m_err",   128'(wr_err),   128'(e_err));
    chk("m_key",   key_round_rd,   e_key);
  endtask

  task automatic wr(input int a, input logic [63:0] d);
    in_t v = nop();
    v.en = 1; v.addr = 5'(a); v.data = d;
    cyc(v);
  endtask

  task automatic kr();
    in_t v = nop();
    v.kr = 1;
    cyc(v);
  endtask

  task automatic st(input bit [1:0] m, input bit d);
    in_t v = nop();
    v.start = 1; v.mode = m; v.dir = d;
    cyc(v);
  endtask

  task automatic kl();
    in_t v = nop();
    v.kill = 1;
    cyc(v);
  endtask

  initial begin
    vec_t tbl[18];
    logic [127:0] saved;
    in_t v;

    // Table: kill, key_ready in IDLE, then a mode-01 start together with key_ready.
    for (int i = 0; i < 18; i++) begin
      tbl[i].i = nop(); tbl[i].idx = 0; tbl[i].valid = 1; tbl[i].last = 0; tbl[i].err = 0;
    end
    tbl[0].i.kill = 1;  tbl[0].valid = 0;
    tbl[1].i.kr = 1;    tbl[1].valid = 0;
    tbl[2].i.start = 1; tbl[2].i.kr = 1; tbl[2].i.mode = 2'b01;
    for (int i = 3; i <= 14; i++) begin
      tbl[i].i.kr = 1; tbl[i].idx = i - 2; tbl[i].last = (i == 14);
    end
    tbl[15].i.kr = 1;
    tbl[16].i.en = 1; tbl[16].i.addr = 5'd31; tbl[16].i.data = ONES; tbl[16].err = 1;

    kl(); kl();
    chk("rst_key", key_round_rd, 128'h0);
    chk("rst_idx", 128'(rk_idx), 128'h0);
    chk("rst_valid", 128'(rk_valid), 128'h0);

    // Forward AES-128 walk over a recognisable pattern.
    for (int a = 0; a < 22; a++) wr(a, {16'(16'hA000 + a), 48'h0});
    kr();
    chk("idle_kr", 128'(rk_valid), 128'h0);
    st(2'b00, 1'b0);
    chk("enc_k0", key_round_rd, pat_key(0));
    for (int k = 1; k <= 10; k++) begin
      kr();
      chk("enc_idx", 128'(rk_idx), 128'(k));
      chk("enc_key", key_round_rd, pat_key(k));
      chk("enc_last", 128'(rk_last), 128'(k == 10));
    end
    kr();
    chk("enc_wrap", 128'(rk_idx), 128'h0);

    // Reverse AES-256 walk.
    for (int a = 22; a < 30; a++) wr(a, {16'(16'hA000 + a), 48'h0});
    st(2'b10, 1'b1);
    chk("dec_first", 128'(rk_idx), 128'd14);
    chk("dec_first_last", 128'(rk_last), 128'h0);
    for (int k = 0; k < 14; k++) kr();
    chk("dec_end", 128'(rk_idx), 128'h0);
    chk("dec_end_last", 128'(rk_last), 128'h1);
    kr();
    chk("dec_wrap", 128'(rk_idx), 128'd14);

    // Out-of-range write: one-cycle error pulse, storage untouched.
    wr(30, ONES);
    chk("err_pulse", 128'(wr_err), 128'h1);
    cyc(nop());
    chk("err_clear", 128'(wr_err), 128'h0);

    // Kill mid-sequence.
    st(2'b00, 1'b0);
    for (int k = 0; k < 5; k++) kr();
    chk("pre_kill", 128'(rk_idx), 128'd5);
    kl();
    chk("kill_key", key_round_rd, 128'h0);
    chk("kill_valid", 128'(rk_valid), 128'h0);
    kr();
    chk("kill_kr", 128'(rk_idx), 128'h0);
    st(2'b00, 1'b0);
    chk("kill_k0", key_round_rd, pat_key(0));

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].i);
      chk("tbl_idx",   128'(rk_idx),   128'(tbl[i].idx));
      chk("tbl_valid", 128'(rk_valid), 128'(tbl[i].valid));
      chk("tbl_last",  128'(rk_last),  128'(tbl[i].last));
      chk("tbl_err",   128'(wr_err),   128'(tbl[i].err));
    end

    // Rewrite a displayed key: visible only after it is re-selected.
    st(2'b00, 1'b0);
    kr();
    saved = key_round_rd;
    wr(2, ONES);
    chk("rw_hold", key_round_rd, saved);
    cyc(nop());
    chk("rw_hold2", key_round_rd, saved);
    kr();
    st(2'b00, 1'b0);
    kr();
    chk("rw_new", key_round_rd[127:64], 128'(ONES));

    for (int n = 0; n < 600; n++) begin
      v = nop();
      v.kill  = ($urandom_range(0, 99) == 0);
      v.start = ($urandom_range(0, 19) == 0);
      v.kr    = ($urandom_range(0, 2) == 0);
      v.mode  = 2'($urandom_range(0, 3));
      v.dir   = 1'($urandom_range(0, 1));
      v.en    = ($urandom_range(0, 4) == 0);
      v.addr  = 5'($urandom_range(0, 31));
      v.data  = {$urandom, $urandom};
      cyc(v);
    end
    cyc(nop());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
